// File: rtl/sisc_pkg.sv
// Shared constants and types for the handshaking SISC multicycle controller.
package sisc_pkg;

  localparam int unsigned OP_NOOP = 0;
  localparam int unsigned OP_LOD  = 1;
  localparam int unsigned OP_STR  = 2;
  localparam int unsigned OP_SWP  = 3;
  localparam int unsigned OP_BRA  = 4;
  localparam int unsigned OP_BRR  = 5;
  localparam int unsigned OP_BNE  = 6;
  localparam int unsigned OP_BNR  = 7;
  localparam int unsigned OP_ALU  = 8;
  localparam int unsigned OP_HLT  = 15;

  localparam int unsigned AM_IMM = 8;

  localparam logic [1:0] ALU_OP_RR   = 2'b00;
  localparam logic [1:0] ALU_OP_IMM  = 2'b01;
  localparam logic [1:0] ALU_OP_PASS = 2'b10;

  typedef enum logic [3:0] {
    ST_START0  = 4'd0,
    ST_START1  = 4'd1,
    ST_FETCH   = 4'd2,
    ST_DECODE  = 4'd3,
    ST_EXECUTE = 4'd4,
    ST_MEM     = 4'd5,
    ST_WB      = 4'd6,
    ST_WB2     = 4'd7,
    ST_HALT    = 4'd8,
    ST_ERR     = 4'd9
  } state_t;

  // One-hot view of the opcode; undefined opcodes leave every bit clear and run as NOOP.
  typedef struct packed {
    logic lod;
    logic str;
    logic swp;
    logic bra;
    logic brr;
    logic bne;
    logic bnr;
    logic alu;
    logic hlt;
  } instr_t;

endpackage

// File: rtl/sisc_wait_timer.sv
// Bounded wait counter for memory handshakes; expired flags that the
// pending request has waited WAIT_MAX cycles without an acknowledge.
module sisc_wait_timer
  import sisc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (count_q == CW'(WAIT_MAX));

  // Saturates at WAIT_MAX so the flag stays stable until the FSM reacts.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sisc_ctrl_hs.sv
// SISC multicycle control FSM with memory request/ack handshakes, bounded
// waits, two-cycle SWP writeback, HALT/ERR states and a retired counter.
module sisc_ctrl_hs
  import sisc_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OP_W-1:0]  opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             im_req,
  output logic             dm_req,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             br_sel,
  output logic             pc_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_rst,
  output logic             rb_sel,
  output logic             mm_sel,
  output logic             dm_we,
  output logic             swp_sel,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  state_t state_q, state_d;
  logic pc_sel_q, pc_sel_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  instr_t ins;
  logic imm, mm_zero, cond_hit, taken;
  logic timer_clear, timer_en, timer_expired, ack_taken, retire;

  always_comb begin
    ins = '0;
    case (opcode)
      OP_W'(OP_LOD): ins.lod = 1'b1;
      OP_W'(OP_STR): ins.str = 1'b1;
      OP_W'(OP_SWP): ins.swp = 1'b1;
      OP_W'(OP_BRA): ins.bra = 1'b1;
      OP_W'(OP_BRR): ins.brr = 1'b1;
      OP_W'(OP_BNE): ins.bne = 1'b1;
      OP_W'(OP_BNR): ins.bnr = 1'b1;
      OP_W'(OP_ALU): ins.alu = 1'b1;
      OP_W'(OP_HLT): ins.hlt = 1'b1;
      default:       ins = '0;
    endcase
  end

  assign imm      = (mm == MM_W'(AM_IMM));
  assign mm_zero  = (mm == '0);
  assign cond_hit = |(stat & mm);
  assign taken    = ((ins.bra | ins.brr) & cond_hit) | ((ins.bne | ins.bnr) & ~cond_hit);

  // pc_sel is driven from its next value so a new selection reaches the PC mux
  // in the same cycle as pc_write, while the flop holds it in between.
  assign pc_sel  = pc_sel_d;
  assign retired = retired_q;

  always_comb begin
    state_d   = state_q;
    pc_sel_d  = pc_sel_q;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    br_sel    = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_rst    = 1'b0;
    rb_sel    = 1'b0;
    mm_sel    = 1'b0;
    dm_we     = 1'b0;
    swp_sel   = 1'b0;
    alu_op    = ALU_OP_PASS;
    halted    = 1'b0;
    err       = 1'b0;
    timer_en  = 1'b0;
    ack_taken = 1'b0;

    case (state_q)
      ST_START0: state_d = ST_START1;
      ST_START1: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ack_taken = 1'b1;
          ir_load   = 1'b1;
          pc_sel_d  = 1'b0;
          pc_write  = 1'b1;
          state_d   = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DECODE: begin
        br_sel = ins.bra | ins.bne;
        if (taken) begin
          pc_sel_d = 1'b1;
          pc_write = 1'b1;
        end
        state_d = ins.hlt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (ins.alu) begin
          alu_op = imm ? ALU_OP_IMM : ALU_OP_RR;
        end
        if (ins.lod | ins.str) begin
          if (imm) alu_op = ALU_OP_IMM;
          else     mm_sel = 1'b1;
          state_d = ST_MEM;
        end else if (ins.alu | ins.swp) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (imm) alu_op = ALU_OP_IMM;
        else     mm_sel = 1'b1;
        dm_req = 1'b1;
        dm_we  = ins.str;
        if (dm_ack) begin
          ack_taken = 1'b1;
          state_d   = ins.str ? ST_FETCH : ST_WB;
        end else if (timer_expired) begin
          state_d = ST_ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_WB: begin
        rb_sel = 1'b1;
        rf_we  = ins.alu | ins.lod | ins.swp;
        if (ins.lod) begin
          wb_sel = 1'b1;
          mm_sel = mm_zero;
        end
        state_d = ins.swp ? ST_WB2 : ST_FETCH;
      end
      ST_WB2: begin
        rf_we   = 1'b1;
        swp_sel = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      ST_ERR:  err = 1'b1;
      default: state_d = ST_START1;
    endcase
  end

  // An instruction retires on its final cycle; START1 -> FETCH is not one.
  always_comb begin
    timer_clear = ack_taken ||
                  ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)));
    retire = ((state_d == ST_FETCH) &&
              (state_q inside {ST_EXECUTE, ST_MEM, ST_WB, ST_WB2})) ||
             ((state_q == ST_DECODE) && (state_d == ST_HALT));
    retired_d = retired_q + CNT_W'(retire);
  end

  sisc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst_f   (rst_f),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q   <= ST_START1;
      pc_sel_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_sel_q  <= pc_sel_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// Self-checking bench for sisc_ctrl_hs: per-instruction output profiles are
// compared against a profile model derived from the instruction semantics.
module tb_sisc_ctrl_hs;

  localparam int OP_W     = 4;
  localparam int MM_W     = 4;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  logic [OP_W-1:0] opcode = '0;
  logic [MM_W-1:0] mm = '0;
  logic [MM_W-1:0] stat = '0;
  logic im_ack = 1'b0;
  logic dm_ack = 1'b0;
  logic im_req, dm_req, rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst;
  logic rb_sel, mm_sel, dm_we, swp_sel, halted, err;
  logic [1:0] alu_op;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  sisc_ctrl_hs #(
    .OP_W(OP_W), .MM_W(MM_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .im_ack(im_ack), .dm_ack(dm_ack), .im_req(im_req), .dm_req(dm_req),
    .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .pc_sel(pc_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_rst(pc_rst), .rb_sel(rb_sel),
    .mm_sel(mm_sel), .dm_we(dm_we), .swp_sel(swp_sel), .alu_op(alu_op),
    .halted(halted), .err(err), .retired(retired)
  );

  typedef struct {
    int cycles;
    int rf_we;
    int swp_sel;
    int swp_pair;
    int dm_req;
    int dm_we;
    int wb_sel;
    int pc_write;
    int taken;
    int br_sel;
    int alu00;
    int alu01;
    int mm_sel;
    int rb_sel;
    int last_pc_sel;
  } prof_t;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;
  prof_t obs;
  bit timed_out;

  // Expected per-instruction profile from the instruction semantics.
  function automatic prof_t model(input logic [3:0] op, input logic [3:0] mm_v,
                                  input logic [3:0] stat_v, input int iw, input int dw);
    prof_t p;
    bit mem_op, imm, hit, tk;
    p = '{default: 0};
    mem_op = (op == 4'd1) || (op == 4'd2);
    imm    = (mm_v == 4'd8);
    hit    = (stat_v & mm_v) != 4'd0;
    tk     = ((op == 4'd4 || op == 4'd5) && hit) || ((op == 4'd6 || op == 4'd7) && !hit);
    case (op)
      4'd1:    p.cycles = 5 + dw;
      4'd2:    p.cycles = 4 + dw;
      4'd3:    p.cycles = 5;
      4'd8:    p.cycles = 4;
      4'd15:   p.cycles = 2;
      default: p.cycles = 3;
    endcase
    p.cycles      += iw;
    p.rf_we        = (op == 4'd8 || op == 4'd1) ? 1 : (op == 4'd3) ? 2 : 0;
    p.swp_sel      = (op == 4'd3) ? 1 : 0;
    p.swp_pair     = p.swp_sel;
    p.dm_req       = mem_op ? dw + 1 : 0;
    p.dm_we        = (op == 4'd2) ? dw + 1 : 0;
    p.wb_sel       = (op == 4'd1) ? 1 : 0;
    p.taken        = tk ? 1 : 0;
    p.pc_write     = 1 + p.taken;
    p.br_sel       = (op == 4'd4 || op == 4'd6) ? 1 : 0;
    p.alu00        = (op == 4'd8 && !imm) ? 1 : 0;
    p.alu01        = (op == 4'd8 && imm) ? 1 : (mem_op && imm) ? dw + 2 : 0;
    p.mm_sel       = ((mem_op && !imm) ? dw + 2 : 0) + ((op == 4'd1 && mm_v == 4'd0) ? 1 : 0);
    p.rb_sel       = (op == 4'd8 || op == 4'd1 || op == 4'd3) ? 1 : 0;
    p.last_pc_sel  = p.taken;
    return p;
  endfunction

  // Runs one instruction from the first FETCH cycle until the next FETCH, HALT or ERR,
  // answering each request after the given number of wait cycles.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] mm_v,
                           input logic [3:0] stat_v, input int iw, input int dw);
    int iseen, dseen;
    bit left, prev_rf;
    obs = '{default: 0};
    opcode = op; mm = mm_v; stat = stat_v;
    iseen = 0; dseen = 0; left = 0; prev_rf = 0; timed_out = 1;
    for (int k = 0; k < 300; k++) begin
      if (k > 0) @(negedge clk);
      if ((left && (im_req || halted)) || err) begin
        timed_out = 0;
        break;
      end
      if (im_req) begin im_ack = (iseen == iw); iseen++; end
      else im_ack = 1'($urandom_range(0, 1));
      if (dm_req) begin dm_ack = (dseen == dw); dseen++; end
      else dm_ack = 1'($urandom_range(0, 1));
      #1;
      obs.cycles++;
      if (rf_we) obs.rf_we++;
      if (swp_sel) obs.swp_sel++;
      if (swp_sel && rf_we && prev_rf) obs.swp_pair++;
      if (dm_req) obs.dm_req++;
      if (dm_we) obs.dm_we++;
      if (wb_sel) obs.wb_sel++;
      if (pc_write) obs.pc_write++;
      if (pc_write && pc_sel) obs.taken++;
      if (br_sel) obs.br_sel++;
      if (alu_op == 2'b00) obs.alu00++;
      if (alu_op == 2'b01) obs.alu01++;
      if (mm_sel) obs.mm_sel++;
      if (rb_sel) obs.rb_sel++;
      obs.last_pc_sel = int'(pc_sel);
      prev_rf = rf_we;
      if (im_req && im_ack) left = 1;
    end
    im_ack = 1'b0; dm_ack = 1'b0;
    if (timed_out) $display("[TB] FAIL run_instr_bound: no completion within 300 cycles (op=%0d)", op);
    if (timed_out) failures++;
  endtask

  task automatic apply_reset();
    rst_f = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    exp_retired = 0;
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (pc_rst !== 1'b1) begin failures++; $display("[TB] FAIL reset_pc_rst got=%0b exp=1", pc_rst); end
    checks++; if (im_req !== 1'b0 || dm_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0b%0b exp=00", im_req, dm_req); end
    checks++; if (retired !== '0) begin failures++; $display("[TB] FAIL reset_retired got=%0d exp=0", retired); end
    checks++; if (halted !== 1'b0 || err !== 1'b0 || pc_sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_status got=%0b%0b%0b exp=000", halted, err, pc_sel); end
    checks++; if (alu_op !== 2'b10 || rf_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_defaults alu_op=%0b rf_we=%0b exp=10/0", alu_op, rf_we); end
    rst_f = 1'b1;
    #1;
    checks++; if (pc_rst !== 1'b1) begin failures++; $display("[TB] FAIL release_pc_rst got=%0b exp=1", pc_rst); end
    @(negedge clk);
    #1;
    checks++; if (pc_rst !== 1'b0 || im_req !== 1'b1) begin failures++; $display("[TB] FAIL first_fetch pc_rst=%0b im_req=%0b exp=0/1", pc_rst, im_req); end
    exp_retired = 0;
  endtask

  task automatic test_alu_rr();
    run_instr(4'd8, 4'd0, 4'd0, 0, 0);
    exp_retired++;
    checks++; if (obs.cycles !== 4) begin failures++; $display("[TB] FAIL alu_latency got=%0d exp=4", obs.cycles); end
    checks++; if (obs.alu00 !== 1) begin failures++; $display("[TB] FAIL alu_rr_op got=%0d exp=1", obs.alu00); end
    checks++; if (obs.rf_we !== 1 || obs.rb_sel !== 1) begin failures++; $display("[TB] FAIL alu_wb rf_we=%0d rb_sel=%0d exp=1/1", obs.rf_we, obs.rb_sel); end
    checks++; if (retired !== CNT_W'(1)) begin failures++; $display("[TB] FAIL alu_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_branch();
    run_instr(4'd4, 4'b0010, 4'b0010, 0, 0);
    exp_retired++;
    checks++; if (obs.taken !== 1 || obs.br_sel !== 1) begin failures++; $display("[TB] FAIL bra_taken taken=%0d br_sel=%0d exp=1/1", obs.taken, obs.br_sel); end
    checks++; if (obs.last_pc_sel !== 1) begin failures++; $display("[TB] FAIL bra_pc_sel_hold got=%0d exp=1", obs.last_pc_sel); end
    run_instr(4'd4, 4'b0100, 4'b0010, 0, 0);
    exp_retired++;
    checks++; if (obs.pc_write !== 1 || obs.cycles !== 3) begin failures++; $display("[TB] FAIL bra_not_taken pc_write=%0d cycles=%0d exp=1/3", obs.pc_write, obs.cycles); end
  endtask

  task automatic test_lod_wait();
    run_instr(4'd1, 4'd8, 4'd0, 0, 3);
    exp_retired++;
    checks++; if (obs.dm_req !== 4 || obs.dm_we !== 0) begin failures++; $display("[TB] FAIL lod_mem dm_req=%0d dm_we=%0d exp=4/0", obs.dm_req, obs.dm_we); end
    checks++; if (obs.wb_sel !== 1 || obs.rf_we !== 1) begin failures++; $display("[TB] FAIL lod_wb wb_sel=%0d rf_we=%0d exp=1/1", obs.wb_sel, obs.rf_we); end
    checks++; if (obs.cycles !== 8) begin failures++; $display("[TB] FAIL lod_latency got=%0d exp=8", obs.cycles); end
  endtask

  task automatic test_swp();
    run_instr(4'd3, 4'd0, 4'd0, 0, 0);
    exp_retired++;
    checks++; if (obs.rf_we !== 2 || obs.swp_pair !== 1) begin failures++; $display("[TB] FAIL swp_wb rf_we=%0d pair=%0d exp=2/1", obs.rf_we, obs.swp_pair); end
    checks++; if (retired !== CNT_W'(exp_retired)) begin failures++; $display("[TB] FAIL swp_retired got=%0d exp=%0d", retired, exp_retired % (1 << CNT_W)); end
  endtask

  task automatic test_fetch_boundary();
    run_instr(4'd0, 4'd3, 4'd1, WAIT_MAX, 0);
    exp_retired++;
    checks++; if (err !== 1'b0 || obs.cycles !== 3 + WAIT_MAX) begin failures++; $display("[TB] FAIL fetch_max_wait err=%0b cycles=%0d exp=0/%0d", err, obs.cycles, 3 + WAIT_MAX); end
  endtask

  task automatic test_random();
    logic [3:0] op, mv, sv;
    int iw, dw, r;
    prof_t e;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 14));
      r  = $urandom_range(0, 7);
      mv = (r == 0) ? 4'd8 : (r == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      sv = 4'($urandom_range(0, 15));
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      run_instr(op, mv, sv, iw, dw);
      e = model(op, mv, sv, iw, dw);
      exp_retired++;
      checks++; if (obs.cycles !== e.cycles) begin failures++; $display("[TB] FAIL rnd_cycles op=%0d got=%0d exp=%0d", op, obs.cycles, e.cycles); end
      checks++; if (obs.rf_we !== e.rf_we || obs.swp_sel !== e.swp_sel || obs.rb_sel !== e.rb_sel || obs.wb_sel !== e.wb_sel) begin failures++; $display("[TB] FAIL rnd_wb op=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", op, obs.rf_we, obs.swp_sel, obs.rb_sel, obs.wb_sel, e.rf_we, e.swp_sel, e.rb_sel, e.wb_sel); end
      checks++; if (obs.dm_req !== e.dm_req || obs.dm_we !== e.dm_we) begin failures++; $display("[TB] FAIL rnd_mem op=%0d got=%0d/%0d exp=%0d/%0d", op, obs.dm_req, obs.dm_we, e.dm_req, e.dm_we); end
      checks++; if (obs.pc_write !== e.pc_write || obs.taken !== e.taken || obs.br_sel !== e.br_sel || obs.last_pc_sel !== e.last_pc_sel) begin failures++; $display("[TB] FAIL rnd_branch op=%0d mm=%0d stat=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", op, mv, sv, obs.pc_write, obs.taken, obs.br_sel, obs.last_pc_sel, e.pc_write, e.taken, e.br_sel, e.last_pc_sel); end
      checks++; if (obs.alu00 !== e.alu00 || obs.alu01 !== e.alu01 || obs.mm_sel !== e.mm_sel) begin failures++; $display("[TB] FAIL rnd_addr op=%0d mm=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", op, mv, obs.alu00, obs.alu01, obs.mm_sel, e.alu00, e.alu01, e.mm_sel); end
      checks++; if (retired !== CNT_W'(exp_retired)) begin failures++; $display("[TB] FAIL rnd_retired got=%0d exp=%0d", retired, exp_retired % (1 << CNT_W)); end
    end
  endtask

  task automatic test_halt();
    int bad;
    run_instr(4'd15, 4'd0, 4'd0, 0, 0);
    exp_retired++;
    checks++; if (halted !== 1'b1 || obs.cycles !== 2) begin failures++; $display("[TB] FAIL halt_entry halted=%0b cycles=%0d exp=1/2", halted, obs.cycles); end
    checks++; if (retired !== CNT_W'(exp_retired)) begin failures++; $display("[TB] FAIL halt_retired got=%0d exp=%0d", retired, exp_retired % (1 << CNT_W)); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      im_ack = 1'b1; dm_ack = 1'b1;
      #1;
      if (im_req !== 1'b0 || dm_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    im_ack = 1'b0; dm_ack = 1'b0;
    checks++; if (bad !== 0 || retired !== CNT_W'(exp_retired)) begin failures++; $display("[TB] FAIL halt_absorbing bad_cycles=%0d retired=%0d exp=0/%0d", bad, retired, exp_retired % (1 << CNT_W)); end
    rst_f = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || pc_rst !== 1'b1) begin failures++; $display("[TB] FAIL halt_exit halted=%0b pc_rst=%0b exp=0/1", halted, pc_rst); end
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    exp_retired = 0;
  endtask

  task automatic test_timeout();
    int bad;
    run_instr(4'd2, 4'd0, 4'd0, 0, 1000);
    checks++; if (obs.dm_req !== WAIT_MAX + 1 || obs.dm_we !== WAIT_MAX + 1) begin failures++; $display("[TB] FAIL timeout_wait dm_req=%0d dm_we=%0d exp=%0d", obs.dm_req, obs.dm_we, WAIT_MAX + 1); end
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_err got=%0b exp=1", err); end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      im_ack = 1'b1;
      #1;
      if (im_req !== 1'b0 || dm_req !== 1'b0 || err !== 1'b1) bad++;
    end
    im_ack = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL err_absorbing bad_cycles=%0d exp=0", bad); end
    apply_reset();
    #1;
    checks++; if (err !== 1'b0 || im_req !== 1'b1) begin failures++; $display("[TB] FAIL err_cleared err=%0b im_req=%0b exp=0/1", err, im_req); end
  endtask

  task automatic test_reset_mid_mem();
    bit seen;
    opcode = 4'd2; mm = 4'd0; stat = 4'd0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      im_ack = im_req;
      dm_ack = 1'b0;
      #1;
      if (dm_req) seen = 1;
    end
    im_ack = 1'b0;
    checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL mid_mem_reach got=%0b exp=1", seen); end
    rst_f = 1'b0;
    #1;
    checks++; if (dm_req !== 1'b0 || dm_we !== 1'b0 || pc_rst !== 1'b1) begin failures++; $display("[TB] FAIL mid_mem_reset dm_req=%0b dm_we=%0b pc_rst=%0b exp=0/0/1", dm_req, dm_we, pc_rst); end
    @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    exp_retired = 0;
  endtask

  initial begin
    test_reset();
    test_alu_rr();
    test_branch();
    test_lod_wait();
    test_swp();
    test_fetch_boundary();
    test_random();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
